// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, 1-cycle-latency RAM between instruction fetch and data load/store.
// Data wins by default; a saturating streak counter bounds how long a contending fetch waits.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_inst_addr,
    input  logic                  i_inst_re,
    output logic [31:0]           o_inst_data,
    output logic                  o_inst_valid,
    output logic                  o_inst_stall,
    input  logic [ADDR_WIDTH-1:0] i_data_addr,
    input  logic [31:0]           i_data_wdata,
    input  logic [3:0]            i_data_be,
    input  logic                  i_data_we,
    input  logic                  i_data_re,
    output logic [31:0]           o_data_rdata,
    output logic                  o_data_valid,
    output logic                  o_data_stall,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [3:0]            o_mem_be,
    output logic [ADDR_WIDTH-3:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic [31:0]           i_mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

    logic       inst_req_s;
    logic       data_req_s;
    logic       grant_inst_s;
    logic       grant_data_s;
    logic [3:0] streak_q;
    logic [3:0] streak_d;
    owner_e     owner_q;
    owner_e     owner_d;
    logic       unused_addr_bits_s;

    assign inst_req_s         = i_inst_re;
    assign data_req_s         = i_data_re | i_data_we;
    assign unused_addr_bits_s = ^{i_inst_addr[1:0], i_data_addr[1:0]};

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
        if (i_rst) begin
            grant_inst_s = 1'b0;
            grant_data_s = 1'b0;
        end else if (inst_req_s && data_req_s) begin
            if (streak_q == MAX_STREAK) begin
                grant_inst_s = 1'b1;
            end else begin
                grant_data_s = 1'b1;
            end
        end else if (inst_req_s) begin
            grant_inst_s = 1'b1;
        end else if (data_req_s) begin
            grant_data_s = 1'b1;
        end else begin
            grant_inst_s = 1'b0;
            grant_data_s = 1'b0;
        end
    end

    // RAM port drive and stall generation.
    always_comb begin
        o_mem_en     = grant_inst_s | grant_data_s;
        o_mem_we     = grant_data_s & i_data_we;
        o_mem_be     = (grant_data_s && i_data_we) ? i_data_be : 4'b1111;
        o_mem_addr   = grant_inst_s ? i_inst_addr[ADDR_WIDTH-1:2] : i_data_addr[ADDR_WIDTH-1:2];
        o_mem_wdata  = i_data_wdata;
        o_inst_stall = inst_req_s & ~grant_inst_s;
        o_data_stall = data_req_s & ~grant_data_s;
    end

    // Next streak count and response owner; a write (even with re high) owns no response.
    always_comb begin
        streak_d = 4'd0;
        owner_d  = OWN_NONE;
        if (grant_data_s && inst_req_s) begin
            streak_d = (streak_q >= MAX_STREAK) ? MAX_STREAK : streak_q + 4'd1;
        end else begin
            streak_d = 4'd0;
        end
        if (grant_inst_s) begin
            owner_d = OWN_INST;
        end else if (grant_data_s && !i_data_we) begin
            owner_d = OWN_DATA;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            streak_q <= 4'd0;
            owner_q  <= OWN_NONE;
        end else begin
            streak_q <= streak_d;
            owner_q  <= owner_d;
        end
    end

    // Response routing; reset masks a response already in flight.
    always_comb begin
        o_inst_valid = (owner_q == OWN_INST) & ~i_rst;
        o_data_valid = (owner_q == OWN_DATA) & ~i_rst;
        o_inst_data  = o_inst_valid ? i_mem_rdata : 32'h0000_0033;
        o_data_rdata = o_data_valid ? i_mem_rdata : 32'h0000_0000;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural 1-cycle RAM.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] inst_addr;
    logic        inst_re;
    logic [31:0] inst_data;
    logic        inst_valid;
    logic        inst_stall;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;
    logic        data_we;
    logic        data_re;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        data_stall;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] ram [0:255];

    int checks;
    int failures;

    mem_port_arbiter #(.ADDR_WIDTH(32), .MAX_DATA_STREAK(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_inst_addr(inst_addr), .i_inst_re(inst_re),
        .o_inst_data(inst_data), .o_inst_valid(inst_valid), .o_inst_stall(inst_stall),
        .i_data_addr(data_addr), .i_data_wdata(data_wdata), .i_data_be(data_be),
        .i_data_we(data_we), .i_data_re(data_re),
        .o_data_rdata(data_rdata), .o_data_valid(data_valid), .o_data_stall(data_stall),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_be(mem_be),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: preload port, byte-enabled write, registered read.
    always @(posedge clk) begin
        if (load_en) begin
            ram[load_addr] <= load_data;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_addr[7:0]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_re = 1'b0; data_re = 1'b0; data_we = 1'b0;
        inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0; data_be = 4'h0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_re = 1'b1; data_re = 1'b1;
        #1;
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", mem_en); end
        checks++; if ({inst_stall, data_stall} !== 2'b11) begin failures++; $display("FAIL reset_stalls got=%b exp=11", {inst_stall, data_stall}); end
        checks++; if ({inst_valid, data_valid} !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", {inst_valid, data_valid}); end
        checks++; if (inst_data !== 32'h0000_0033) begin failures++; $display("FAIL reset_inst_data got=%h exp=00000033", inst_data); end
        checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL reset_data_rdata got=%h exp=0", data_rdata); end
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_idle();
        step();
        idle_inputs();
        #1;
        checks++; if ({inst_stall, data_stall, mem_en} !== 3'b000) begin failures++; $display("FAIL idle_ctrl got=%b exp=000", {inst_stall, data_stall, mem_en}); end
        checks++; if (inst_data !== 32'h0000_0033) begin failures++; $display("FAIL idle_inst_data got=%h exp=00000033", inst_data); end
    endtask

    task automatic test_fetch_only();
        step();
        inst_addr = 32'h0000_0010; inst_re = 1'b1;
        #1;
        checks++; if ({mem_en, mem_we, inst_stall} !== 3'b100) begin failures++; $display("FAIL fetch_ctrl got=%b exp=100", {mem_en, mem_we, inst_stall}); end
        checks++; if (mem_addr !== 30'd4) begin failures++; $display("FAIL fetch_addr got=%0d exp=4", mem_addr); end
        step();
        inst_re = 1'b0;
        #1;
        checks++; if ({inst_valid, data_valid} !== 2'b10) begin failures++; $display("FAIL fetch_valid got=%b exp=10", {inst_valid, data_valid}); end
        checks++; if (inst_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fetch_data got=%h exp=deadbeef", inst_data); end
        step();
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fetch_valid_once got=%b exp=0", inst_valid); end
    endtask

    task automatic test_contention();
        step();
        inst_addr = 32'h0; inst_re = 1'b1; data_addr = 32'h8; data_re = 1'b1;
        #1;
        checks++; if ({inst_stall, data_stall} !== 2'b10) begin failures++; $display("FAIL cont_stalls got=%b exp=10", {inst_stall, data_stall}); end
        checks++; if (mem_addr !== 30'd2) begin failures++; $display("FAIL cont_addr got=%0d exp=2", mem_addr); end
        step();
        data_re = 1'b0;
        #1;
        checks++; if ({inst_stall, mem_addr} !== {1'b0, 30'd0}) begin failures++; $display("FAIL cont_fetch_grant got=%b/%0d exp=0/0", inst_stall, mem_addr); end
        checks++; if ({data_valid, data_rdata} !== {1'b1, 32'h2222_2222}) begin failures++; $display("FAIL cont_data_resp got=%b/%h exp=1/22222222", data_valid, data_rdata); end
        step();
        inst_re = 1'b0;
        #1;
        checks++; if ({inst_valid, inst_data} !== {1'b1, 32'h0000_0013}) begin failures++; $display("FAIL cont_inst_resp got=%b/%h exp=1/00000013", inst_valid, inst_data); end
        step();
    endtask

    task automatic test_starvation();
        logic [5:0] exp_ds;
        exp_ds = 6'b010000;
        step();
        inst_addr = 32'h0; inst_re = 1'b1; data_addr = 32'h8; data_re = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if ({inst_stall, data_stall, mem_en} !== {~exp_ds[c], exp_ds[c], 1'b1}) begin
                failures++;
                $display("FAIL starve_cycle%0d got=%b exp=%b", c, {inst_stall, data_stall, mem_en}, {~exp_ds[c], exp_ds[c], 1'b1});
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_byte_write();
        step();
        data_addr = 32'h0000_0005; data_be = 4'b0010; data_wdata = 32'h0000_AB00;
        data_we = 1'b1; data_re = 1'b1;
        #1;
        checks++; if ({mem_en, mem_we, mem_be} !== 6'b110010) begin failures++; $display("FAIL bw_ctrl got=%b exp=110010", {mem_en, mem_we, mem_be}); end
        checks++; if (mem_addr !== 30'd1) begin failures++; $display("FAIL bw_addr got=%0d exp=1", mem_addr); end
        step();
        data_addr = 32'h4; data_we = 1'b0; data_re = 1'b1;
        #1;
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL bw_no_valid got=%b exp=0", data_valid); end
        checks++; if ({mem_we, mem_be} !== 5'b01111) begin failures++; $display("FAIL bw_read_be got=%b exp=01111", {mem_we, mem_be}); end
        step();
        data_re = 1'b0;
        #1;
        checks++; if ({data_valid, data_rdata} !== {1'b1, 32'h1122_AB44}) begin failures++; $display("FAIL bw_readback got=%b/%h exp=1/1122ab44", data_valid, data_rdata); end
        step();
    endtask

    task automatic test_reset_mid_read();
        int n;
        bit found;
        step();
        inst_addr = 32'h0; inst_re = 1'b1; data_addr = 32'h8; data_re = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        checks++; if ({data_valid, mem_en} !== 2'b00) begin failures++; $display("FAIL rmr_drop got=%b exp=00", {data_valid, mem_en}); end
        checks++; if ({inst_stall, data_stall} !== 2'b11) begin failures++; $display("FAIL rmr_stalls got=%b exp=11", {inst_stall, data_stall}); end
        step();
        checks++; if ({data_valid, mem_en} !== 2'b00) begin failures++; $display("FAIL rmr_held got=%b exp=00", {data_valid, mem_en}); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rmr_after got=%b exp=0", data_valid); end
        n = 0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!found) begin
                if (inst_stall === 1'b0) begin
                    found = 1'b1;
                end else begin
                    n++;
                    step();
                end
            end
        end
        checks++; if (!found || n != 4) begin failures++; $display("FAIL rmr_streak got=%0d found=%0b exp=4", n, found); end
        idle_inputs();
        step();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; load_en = 1'b0; load_addr = 8'h0; load_data = 32'h0;
        idle_inputs();
        preload(8'd0, 32'h0000_0013);
        preload(8'd1, 32'h1122_3344);
        preload(8'd2, 32'h2222_2222);
        preload(8'd4, 32'hDEAD_BEEF);
        test_reset();
        test_idle();
        test_fetch_only();
        test_contention();
        test_starvation();
        test_byte_write();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
